p2s_tx: RTL and testbench
=========================

P2S_TX -- requirements
Module: p2s_tx

Interface
REQ-001 Parameter WIDTH, default 8, bits per lane word.
REQ-002 Parameter LANES, default 4, number of serial lanes.
REQ-003 CLK  input  1  single bit-rate clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ENB  input  1  global enable; low stalls the block.
REQ-006 in_valid  input  1  parallel word set present on P0..P3.
REQ-007 P0, P1, P2, P3  input  WIDTH each  parallel word for lane 0..3.
REQ-008 in_ready  output  1  holding buffer can accept a word set.
REQ-009 s_out  output  LANES  serial bit per lane; bit n belongs to lane n.
REQ-010 s_valid  output  1  s_out carries a data bit this cycle.
REQ-011 frame  output  1  high on the cycle carrying bit WIDTH-1 (first bit) of each word.

Function
REQ-012 The block SHALL accept a word set on a rising edge where in_valid, in_ready and ENB are all high, storing P0..P3 in a holding buffer.
REQ-013 in_ready SHALL equal ENB AND (holding buffer empty), with no combinational path from in_valid.
REQ-014 The FSM SHALL have two states: IDLE (shifter empty) and SHIFT (shifter transmitting); its encoding is defined in the shared include.
REQ-015 IDLE -> SHIFT on the edge where the holding buffer is full and ENB is high; that edge moves the buffer into the per-lane shift registers, empties the buffer, and loads the bit counter with WIDTH-1.
REQ-016 Latency: a set accepted on edge k SHALL present bit WIDTH-1 on s_out after edge k+1, and bit 0 after edge k+WIDTH.
REQ-017 Bit order SHALL be MSB first, one bit per CLK cycle, all lanes in lockstep.
REQ-018 In SHIFT, each enabled edge SHALL shift all lanes by one bit and decrement the counter.
REQ-019 At counter 0: if the holding buffer is full, the shifter SHALL reload on the same edge (SHIFT -> SHIFT, no gap bit); otherwise SHIFT -> IDLE.
REQ-020 A new set MAY be accepted while the shifter runs; back-to-back streaming SHALL sustain one word set per WIDTH cycles with no idle cycle.
REQ-021 In IDLE, s_out SHALL be all zeros and s_valid and frame SHALL be low.
REQ-022 s_valid SHALL be high exactly on the WIDTH cycles of each word; frame SHALL be high only on the first of them.
REQ-023 While ENB is low, all registers SHALL hold, no accept occurs, and s_out, s_valid and frame SHALL keep their values; operation resumes mid-word when ENB returns high.
REQ-024 Simultaneous accept and buffer-to-shifter transfer on one edge SHALL NOT occur, because in_ready is low while the buffer is full.
REQ-025 All outputs SHALL be registered, except in_ready, which is a function of registered state and ENB.

Reset
REQ-026 Asserting reset (low) SHALL immediately force: state IDLE, holding buffer empty, shift registers 0, counter 0, s_out 0, s_valid 0, frame 0; in_ready then follows ENB.
REQ-027 Reset asserted mid-word SHALL discard both the partial word and the buffered word; no residual bits are emitted after release.
REQ-028 The first accept after release SHALL be possible on the first rising edge with reset high.

Structure
REQ-029 A shared include p2s_defs SHALL hold WIDTH and LANES defaults and the state encodings IDLE/SHIFT.
REQ-030 One sub-module, p2s_lane (a WIDTH-bit load/shift register with enable and async active-low reset), SHALL be instantiated LANES times; the FSM, counter and holding buffer live in p2s_tx.
REQ-031 The block SHALL be synthesizable to the team cell library, and behavioural and synthesized netlists SHALL match cycle-for-cycle.

Verification
REQ-032 Single word: P3..P0 = A5, 3C, FF, 01 accepted at edge k -> lane0 bits 0,0,0,0,0,0,0,1 and lane3 bits 1,0,1,0,0,1,0,1 on cycles k+1..k+8; frame high at k+1 only.
REQ-033 Back-to-back: in_valid held high with three sets -> 24 consecutive s_valid cycles, frame at offsets 0, 8, 16, in_ready never low for more than 8 cycles.
REQ-034 ENB stall: drop ENB for 5 cycles after bit 4 of a word -> s_out frozen for 5 cycles; the remaining bits 3..0 follow with no loss.
REQ-035 Reset mid-word: assert reset at bit 5 -> outputs 0 immediately; after release with no new input, s_valid stays 0.
REQ-036 Loopback: feed s_out into the team's 4-lane deserializer, aligned on frame -> recovered P0..P3 equal transmitted values for 256 random sets.

Source files
------------

// File: rtl/p2s_defs.sv
// Shared defaults and state encoding for the parallel-to-serial transmitter.
package p2s_defs;

    localparam int P2S_WIDTH = 8;
    localparam int P2S_LANES = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } p2s_state_e;

    // Bit counter width; keeps a one-bit counter legal for WIDTH == 1.
    function automatic int cnt_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/p2s_lane.sv
// One serial lane: WIDTH-bit load/shift register, MSB presented on q.
module p2s_lane
    import p2s_defs::*;
#(
    parameter int WIDTH = P2S_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic             q
);

    logic [WIDTH-1:0] sr;

    // Zero fill means the register is empty again once a word has shifted out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (en) begin
            if (load) begin
                sr <= d;
            end else begin
                sr <= sr << 1;
            end
        end
    end

    assign q = sr[WIDTH-1];

endmodule

// File: rtl/p2s_tx.sv
// Multi-lane parallel-to-serial transmitter with a one-deep holding buffer.
//   state | meaning
//   IDLE  | shifter empty, outputs quiet, waiting for a buffered word set
//   SHIFT | shifter transmitting, counter holds remaining bits after this one
module p2s_tx
    import p2s_defs::*;
#(
    parameter int WIDTH = P2S_WIDTH,
    parameter int LANES = P2S_LANES
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             ENB,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] P0,
    input  logic [WIDTH-1:0] P1,
    input  logic [WIDTH-1:0] P2,
    input  logic [WIDTH-1:0] P3,
    output logic             in_ready,
    output logic [LANES-1:0] s_out,
    output logic             s_valid,
    output logic             frame
);

    localparam int                CNT_W    = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    p2s_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic              buf_full;
    logic [WIDTH-1:0]  buf_data [LANES];
    logic [WIDTH-1:0]  p_word   [LANES];
    logic              accept;
    logic              xfer;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            case (i)
                0:       p_word[i] = P0;
                1:       p_word[i] = P1;
                2:       p_word[i] = P2;
                3:       p_word[i] = P3;
                default: p_word[i] = '0;
            endcase
        end
    end

    assign in_ready = ENB & ~buf_full;
    assign accept   = in_valid & in_ready;
    // Buffer moves into the shifter when idle or on the last bit of a word.
    assign xfer     = ENB & buf_full & ((state == IDLE) | (cnt == '0));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            buf_full <= 1'b0;
            s_valid  <= 1'b0;
            frame    <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                buf_data[i] <= '0;
            end
        end else if (ENB) begin
            // accept and xfer never coincide: in_ready is low while full.
            if (accept) begin
                buf_full <= 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    buf_data[i] <= p_word[i];
                end
            end else if (xfer) begin
                buf_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (buf_full) begin
                        state   <= SHIFT;
                        cnt     <= CNT_LAST;
                        s_valid <= 1'b1;
                        frame   <= 1'b1;
                    end
                end
                SHIFT: begin
                    frame <= 1'b0;
                    if (cnt == '0) begin
                        if (buf_full) begin
                            cnt   <= CNT_LAST;
                            frame <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            s_valid <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        p2s_lane #(.WIDTH(WIDTH)) u_lane (
            .clk   (CLK),
            .rst_n (reset),
            .en    (ENB),
            .load  (xfer),
            .d     (buf_data[g]),
            .q     (s_out[g])
        );
    end

endmodule

// File: tb/tb_p2s_tx.sv
// Self-checking bench for p2s_tx: directed table, hand sequences, random vs model.
module tb_p2s_tx;

    localparam int W = 8;
    localparam int L = 4;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          ENB = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  P0 = '0, P1 = '0, P2 = '0, P3 = '0;
    logic          in_ready;
    logic [L-1:0]  s_out;
    logic          s_valid;
    logic          frame;

    always #5 CLK = ~CLK;

    p2s_tx #(.WIDTH(W), .LANES(L)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .ENB      (ENB),
        .in_valid (in_valid),
        .P0       (P0),
        .P1       (P1),
        .P2       (P2),
        .P3       (P3),
        .in_ready (in_ready),
        .s_out    (s_out),
        .s_valid  (s_valid),
        .frame    (frame)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: word n accepted on enabled edge a_n starts (frame) on
    // enabled edge f_n = max(a_n + 1, f_{n-1} + W) and occupies W edges.
    // The holding buffer is full from edge a_n until edge f_n.
    typedef struct {
        int               f;
        logic [4*W-1:0]   w;
    } ws_t;

    ws_t q[$];
    int  e = 0;
    int  last_a = 0;
    int  last_f = 0;
    bit  have = 1'b0;
    int  acc_cnt = 0;

    function automatic bit m_full();
        return have && (last_a <= e) && (e < last_f);
    endfunction

    task automatic model_reset();
        e = 0;
        have = 1'b0;
        q.delete();
    endtask

    task automatic model_edge();
        bit  rdy;
        int  f;
        ws_t t;
        if (reset && ENB) begin
            rdy = !m_full();
            e++;
            if (in_valid && rdy) begin
                f = e + 1;
                if (have && (last_f + W > f)) f = last_f + W;
                t.f = f;
                t.w = {P3, P2, P1, P0};
                q.push_back(t);
                last_a = e;
                last_f = f;
                have = 1'b1;
                acc_cnt++;
            end
        end
    endtask

    task automatic model_expect(output logic [31:0] exp);
        logic [L-1:0] so;
        bit           sv;
        bit           fr;
        int           idx;
        so = '0;
        sv = 1'b0;
        fr = 1'b0;
        while (q.size() > 0 && q[0].f + W <= e) void'(q.pop_front());
        if (q.size() > 0 && q[0].f <= e) begin
            idx = W - 1 - (e - q[0].f);
            for (int l = 0; l < L; l++) so[l] = q[0].w[l*W + idx];
            sv = 1'b1;
            fr = (e == q[0].f);
        end
        exp = {25'b0, so, sv, fr, (ENB && !m_full())};
    endtask

    function automatic logic [31:0] outs();
        return {25'b0, s_out, s_valid, frame, in_ready};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input string name);
        logic [31:0] exp;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        model_expect(exp);
        check(name, outs(), exp);
    endtask

    typedef struct {
        bit         enb;
        bit         vld;
        logic [6:0] exp;   // {s_out[3:0], s_valid, frame, in_ready}
    } vec_t;

    vec_t tbl[15];

    logic [4*W-1:0] sets [3];
    bit             sv_hist [40];
    bit             fr_hist [40];
    bit             rd_hist [40];

    initial begin
        logic [31:0] exp;
        int          first;
        int          run;
        int          low_run;
        int          max_low;
        logic [31:0] fpat;

        // Reset state, in_ready follows ENB during reset.
        ENB = 1'b1;
        #2;
        check("reset_state", outs(), 32'b0000_001);
        @(negedge CLK);
        reset = 1'b1;
        model_reset();

        // Single word with a 5-cycle stall after bit 4.
        tbl[0]  = '{1'b1, 1'b1, 7'b0000_000};
        tbl[1]  = '{1'b1, 1'b0, 7'b1010_111};
        tbl[2]  = '{1'b1, 1'b0, 7'b0010_101};
        tbl[3]  = '{1'b1, 1'b0, 7'b1110_101};
        tbl[4]  = '{1'b1, 1'b0, 7'b0110_101};
        for (int i = 5; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 7'b0110_100};
        tbl[10] = '{1'b1, 1'b0, 7'b0110_101};
        tbl[11] = '{1'b1, 1'b0, 7'b1110_101};
        tbl[12] = '{1'b1, 1'b0, 7'b0010_101};
        tbl[13] = '{1'b1, 1'b0, 7'b1011_101};
        tbl[14] = '{1'b1, 1'b0, 7'b0000_001};

        P0 = 8'h01; P1 = 8'hFF; P2 = 8'h3C; P3 = 8'hA5;
        for (int i = 0; i < 15; i++) begin
            ENB      = tbl[i].enb;
            in_valid = tbl[i].vld;
            cycle("tbl_model");
            check($sformatf("tbl_row%0d", i), outs(), 32'(tbl[i].exp));
        end

        // Back-to-back: three sets streamed with in_valid held high.
        ENB = 1'b1;
        in_valid = 1'b0;
        cycle("b2b_idle");
        for (int s = 0; s < 3; s++) sets[s] = {$urandom(), $urandom()};
        acc_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            in_valid = (acc_cnt < 3);
            {P3, P2, P1, P0} = sets[(acc_cnt < 3) ? acc_cnt : 2];
            cycle("b2b_model");
            sv_hist[c] = s_valid;
            fr_hist[c] = frame;
            rd_hist[c] = in_ready;
        end
        in_valid = 1'b0;
        first = -1;
        for (int c = 39; c >= 0; c--) if (sv_hist[c]) first = c;
        run = 0;
        fpat = '0;
        if (first >= 0) begin
            for (int c = first; c < 40 && sv_hist[c]; c++) run++;
            for (int c = first; c < 40 && c < first + 32; c++)
                if (fr_hist[c]) fpat[c - first] = 1'b1;
        end
        check("b2b_valid_run", 32'(run), 32'd24);
        check("b2b_frame_offsets", fpat, 32'h0001_0101);
        max_low = 0;
        low_run = 0;
        for (int c = 0; c < 40; c++) begin
            low_run = rd_hist[c] ? 0 : low_run + 1;
            if (low_run > max_low) max_low = low_run;
        end
        check("b2b_ready_low_le8", 32'(max_low <= 8), 32'd1);

        // Reset asserted while bit 5 is on the wire.
        {P3, P2, P1, P0} = {$urandom()};
        in_valid = 1'b1;
        cycle("rst_acc");
        in_valid = 1'b0;
        cycle("rst_b7");
        cycle("rst_b6");
        cycle("rst_b5");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_immediate", outs(), 32'b0000_001);
        @(negedge CLK);
        reset = 1'b1;
        run = 0;
        for (int c = 0; c < 12; c++) begin
            cycle("rst_after_model");
            if (s_valid) run++;
        end
        check("rst_no_residual", 32'(run), 32'd0);

        // First edge after release accepts.
        reset = 1'b0;
        model_reset();
        @(negedge CLK);
        reset = 1'b1;
        in_valid = 1'b1;
        {P3, P2, P1, P0} = {$urandom()};
        cycle("rel_accept");
        in_valid = 1'b0;
        cycle("rel_frame");
        check("rel_first_frame", {31'b0, frame}, 32'd1);

        // Randomized traffic with random stalls.
        for (int c = 0; c < 600; c++) begin
            ENB      = ($urandom_range(0, 9) != 0);
            in_valid = $urandom_range(0, 1);
            {P3, P2, P1, P0} = {$urandom()};
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
